seq_div8: RTL and testbench
===========================

Name: seq_div8

Overview:
- Sequential unsigned restoring divider: the inverse of the accumulating adder datapath. It undoes repeated addition by repeated subtraction.
- Takes dividend and divisor on a start handshake and produces quotient and remainder one bit per cycle.
- Sits beside the add/sub accumulator in the lab datapath. Operands come from the switch bank; results go to the LEDs.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits (at least 2).

Ports:
- clk_sys  input  1  system clock; all state changes on its rising edge.
- rst_sys  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend; captured when start is accepted.
- divisor  input  WIDTH  unsigned divisor; captured when start is accepted.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse when the result registers update.
- div_by_zero  output  1  registered flag for the last completed operation.

Behaviour:
- Reset (rst_sys=0, any time, asynchronous):
  - State goes to IDLE.
  - quotient, remainder, busy, done and div_by_zero all go to 0.
  - Internal shift, partial-remainder and count registers clear.
  - An operation in flight is aborted; no done pulse follows reset release.
- States: IDLE, CALC. done is a registered output pulse, not a separate state.
- IDLE, start=1, divisor!=0, on the accepting edge:
  - Latch the operands and clear the partial remainder and count.
  - Go to CALC; busy=1 from that edge.
- IDLE, start=1, divisor==0, on the accepting edge:
  - quotient = all ones, remainder = dividend, div_by_zero=1, done=1 for one cycle.
  - Stay in IDLE; busy stays 0.
- CALC step (one per edge, WIDTH steps total):
  - r = {rem[WIDTH-2:0], q_shift MSB}; q_shift shifts left.
  - trial = r - divisor, computed at WIDTH+1 bits.
  - trial non-negative: rem = trial, new q LSB = 1. Otherwise rem = r, new q LSB = 0.
- On the edge that completes step WIDTH:
  - quotient/remainder load from the internal registers; div_by_zero=0; done=1 for one cycle.
  - busy=0; state returns to IDLE.
- Latency: done is high in the cycle following the WIDTH-th edge after the accepting edge (8 cycles for WIDTH=8).
- start while busy is ignored and not queued. Captured operands are unaffected by input changes during CALC.
- start is accepted in the same cycle done is high (state is already IDLE), allowing back-to-back operations. done drops on the next edge.
- Outputs hold their last result until the next completion; they do not change during CALC.
- Invariant: dividend == quotient*divisor + remainder and remainder < divisor, for divisor != 0.

Decomposition:
- Package seq_div_pkg:
  - state enum div_state_t {IDLE, CALC}
  - localparam DIV_W = 8
  - localparam CNT_W = $clog2(WIDTH+1)
- Sub-module div_step (combinational): inputs shifted partial remainder and divisor; outputs next remainder and quotient bit. It reuses the subtract form of the existing adder/subtractor and is instantiated once.

Test Plan:
- Basic: dividend=100, divisor=7, start one cycle -> busy for 8 cycles, then done=1 with quotient=14, remainder=2, div_by_zero=0.
- Extremes: 255/1 -> q=255, r=0. 5/9 -> q=0, r=5. 0/3 -> q=0, r=0. 255/255 -> q=1, r=0.
- Divide by zero: 37/0 -> done on the first edge, q=8'hFF, r=37, div_by_zero=1, busy never high.
- Start while busy: 200/3 started, then start with 50/5 pulsed mid-CALC -> only q=66, r=2 is produced, a single done pulse, no second operation.
- Back-to-back: start 9/2 asserted in the done cycle of 100/7 -> first result 14 r2, then 8 cycles later 4 r1. div_by_zero clears.
- Reset mid-operation: rst_sys low at step 4 of 100/7 -> all outputs 0 immediately. After release there is no done until a new start; a fresh 100/7 gives 14 r2.

Source files
------------

// File: rtl/seq_div8_pkg.sv
// Shared types and sizes for the sequential restoring divider.
//   div_state_t : controller states (IDLE waits for start, CALC runs the steps)
//   DIV_W       : default operand/result width
//   CNT_W       : width of the step counter for DIV_W steps
package seq_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } div_state_t;

    localparam int unsigned DIV_W = 8;
    localparam int unsigned CNT_W = $clog2(DIV_W + 1);

endpackage

// File: rtl/seq_div8_if.sv
// Handshake and result bundle of the divider.
//   start, dividend, divisor                     : request side (master drives)
//   quotient, remainder, busy, done, div_by_zero : result side (slave drives)
interface seq_div8_if
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/seq_div8_div_step.sv
// One restoring-division step (combinational).
//   r_i       : shifted partial remainder
//   divisor_i : divisor
//   rem_o     : next partial remainder (r_i - divisor_i if that fits, else r_i)
//   q_bit_o   : quotient bit produced by this step
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] trial;

    // Subtract as add of the one's complement plus carry-in; the extra MSB is the borrow.
    assign trial   = {1'b0, r_i} + {1'b1, ~divisor_i} + (WIDTH + 1)'(1);
    assign q_bit_o = ~trial[WIDTH];
    assign rem_o   = q_bit_o ? trial[WIDTH-1:0] : r_i;

endmodule

// File: rtl/seq_div8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk_sys : system clock, rising edge
//   rst_sys : asynchronous active-low reset
//   bus     : slave side of seq_div8_if (start/operands in, results/status out)
module seq_div8
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W
) (
    input  logic         clk_sys,
    input  logic         rst_sys,
    seq_div8_if.slave    bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] qsh_q, qsh_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmo_q, rmo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    // Partial remainder MSB is always zero before the last step, so dropping it is safe.
    assign step_r = {rem_q[WIDTH-2:0], qsh_q[WIDTH-1]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i       (step_r),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    // State and datapath registers.
    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            state_q <= IDLE;
            qsh_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            qsh_q   <= qsh_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rmo_q   <= rmo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        qsh_d   = qsh_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rmo_d   = rmo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quot_d = '1;
                        rmo_d  = bus.dividend;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        qsh_d   = bus.dividend;
                        dvs_d   = bus.divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                qsh_d = {qsh_q[WIDTH-2:0], step_qbit};
                rem_d = step_rem;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quot_d  = {qsh_q[WIDTH-2:0], step_qbit};
                    rmo_d   = step_rem;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rmo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div8.sv
module tb_seq_div8;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    always #5 clk = ~clk;

    seq_div8_if #(.WIDTH(8)) bus ();

    seq_div8 #(.WIDTH(8)) dut (
        .clk_sys (clk),
        .rst_sys (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
        logic       exp_z;
        int         exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle and wait for done; lat counts edges after the accepting edge.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat, output logic busy_ok);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        step();
        bus.start = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.done && lat < 20) begin
            if (!bus.busy) busy_ok = 1'b0;
            step();
            lat++;
        end
        if (!bus.done) chk("done_timeout", 32'(lat), 32'(8));
    endtask

    // Reference result from the arithmetic definition of division.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return {8'hFF, a};
        return {8'(a / b), 8'(a % b)};
    endfunction

    initial begin
        vec_t       vecs[6];
        int         lat;
        logic       bok;
        int         dcount;
        logic [7:0] a, b;
        logic [15:0] m;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 8};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 8};
        vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 8};
        vecs[4] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8};
        vecs[5] = '{8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 0};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        step();
        step();
        chk("rst_q",    32'(bus.quotient),    32'(0));
        chk("rst_r",    32'(bus.remainder),   32'(0));
        chk("rst_busy", 32'(bus.busy),        32'(0));
        chk("rst_done", 32'(bus.done),        32'(0));
        chk("rst_dbz",  32'(bus.div_by_zero), 32'(0));
        rst_n = 1'b1;
        step();

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].dvd, vecs[i].dvs, lat, bok);
            chk($sformatf("vec%0d_q", i),   32'(bus.quotient),    32'(vecs[i].exp_q));
            chk($sformatf("vec%0d_r", i),   32'(bus.remainder),   32'(vecs[i].exp_r));
            chk($sformatf("vec%0d_z", i),   32'(bus.div_by_zero), 32'(vecs[i].exp_z));
            chk($sformatf("vec%0d_lat", i), 32'(lat),             32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_busy", i), 32'(bok),            32'(1));
            step();
            chk($sformatf("vec%0d_done_drop", i), 32'(bus.done),  32'(0));
            chk($sformatf("vec%0d_idle", i),      32'(bus.busy),  32'(0));
        end

        // Start while busy must be ignored; outputs hold during CALC
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
        step();
        bus.start = 1'b0;
        step(); step();
        chk("hold_q_calc", 32'(bus.quotient), 32'(8'hFF));
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
        step();
        bus.start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                dcount++;
                if (dcount == 1) begin
                    chk("busy_ign_q", 32'(bus.quotient),  32'(66));
                    chk("busy_ign_r", 32'(bus.remainder), 32'(2));
                end
            end
            step();
        end
        chk("busy_ign_ndone", 32'(dcount), 32'(1));
        chk("busy_ign_idle",  32'(bus.busy), 32'(0));

        // Back-to-back: divide by zero, then 100/7, then 9/2 started in the done cycle
        do_op(8'd37, 8'd0, lat, bok);
        step();
        do_op(8'd100, 8'd7, lat, bok);
        chk("b2b_first_q", 32'(bus.quotient),    32'(14));
        chk("b2b_first_r", 32'(bus.remainder),   32'(2));
        chk("b2b_dbz_clr", 32'(bus.div_by_zero), 32'(0));
        do_op(8'd9, 8'd2, lat, bok);
        chk("b2b_second_q",   32'(bus.quotient),  32'(4));
        chk("b2b_second_r",   32'(bus.remainder), 32'(1));
        chk("b2b_second_lat", 32'(lat),           32'(8));
        step();

        // Reset in the middle of 100/7
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("mrst_q",    32'(bus.quotient),  32'(0));
        chk("mrst_r",    32'(bus.remainder), 32'(0));
        chk("mrst_busy", 32'(bus.busy),      32'(0));
        chk("mrst_done", 32'(bus.done),      32'(0));
        step();
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.done || bus.busy) dcount++;
        end
        chk("mrst_no_done", 32'(dcount), 32'(0));
        do_op(8'd100, 8'd7, lat, bok);
        chk("mrst_fresh_q", 32'(bus.quotient),  32'(14));
        chk("mrst_fresh_r", 32'(bus.remainder), 32'(2));
        step();

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            m = model(a, b);
            do_op(a, b, lat, bok);
            chk($sformatf("rnd%0d_q(%0d/%0d)", i, a, b), 32'(bus.quotient),    32'(m[15:8]));
            chk($sformatf("rnd%0d_r(%0d/%0d)", i, a, b), 32'(bus.remainder),   32'(m[7:0]));
            chk($sformatf("rnd%0d_z", i),                32'(bus.div_by_zero), 32'(b == 8'd0));
            chk($sformatf("rnd%0d_lat", i),              32'(lat),             32'((b == 8'd0) ? 0 : 8));
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
